pipe_inst_sequencer: RTL

- Instruction issuer for the `pipeline` block: drives the 8-bit `inst` port that `pipeline` consumes.
- Holds a small program RAM of opcodes loaded over a write port. On `start`, issues the program one opcode per cycle.
- Inserts NOP bubbles after WRITE (pipeline drain) and while the pipeline signals `hold`.
- Repeats the program a programmable number of times, then pulses `done`.

---
 rtl/pipe_inst_sequencer_pkg.sv | 18 +
 rtl/pipe_inst_sequencer_if.sv | 29 ++
 rtl/pipe_defs.vh | 11 +
 rtl/pipe_prog_ram.sv | 24 ++
 rtl/pipe_inst_sequencer.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/pipe_inst_sequencer_pkg.sv
// pipe_inst_sequencer shared types and helpers
// Opcode values come from the shared pipe_defs.vh.
package pipe_inst_sequencer_pkg;
`include "pipe_defs.vh"

    typedef logic [7:0] op_t;

    localparam op_t OP_NOP   = `NOP;
    localparam op_t OP_MEM1  = `MEM1;
    localparam op_t OP_MEM2  = `MEM2;
    localparam op_t OP_ADD   = `ADD;
    localparam op_t OP_MULT  = `MULT;
    localparam op_t OP_WRITE = `WRITE;

    function automatic logic is_write(input op_t op);
        return op == OP_WRITE;
    endfunction
endpackage

// File: rtl/pipe_inst_sequencer_if.sv
// pipe_inst_sequencer program/issue bus
// master = controller side, slave = sequencer.
interface pipe_inst_sequencer_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [AW:0]   len;
    logic [7:0]    loops;
    logic          start;
    logic          hold;
    logic [7:0]    inst;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    modport master (
        output prog_we, prog_addr, prog_data,
        output len, loops, start, hold,
        input  inst, busy, done, pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_data,
        input  len, loops, start, hold,
        output inst, busy, done, pc
    );
endinterface

// File: rtl/pipe_defs.vh
// Shared opcode values for the pipeline block
// and everything that issues into it.
`ifndef PIPE_DEFS_VH
`define PIPE_DEFS_VH
`define NOP   8'h00
`define MEM1  8'h01
`define MEM2  8'h02
`define ADD   8'h03
`define MULT  8'h04
`define WRITE 8'h05
`endif

// File: rtl/pipe_prog_ram.sv
// pipe_prog_ram: DEPTHx8 opcode store
// One sync write port, one async read port.
module pipe_prog_ram
    import pipe_inst_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  op_t           wdata_i,
    input  logic [AW-1:0] raddr_i,
    output op_t           rdata_o
);
    op_t mem_q [DEPTH];

    // write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pipe_inst_sequencer.sv
// pipe_inst_sequencer: issues a stored program
// into the pipeline with WRITE drain and hold.
module pipe_inst_sequencer
    import pipe_inst_sequencer_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int WRITE_GAP = 3
) (
    input logic clk,
    input logic resetn,
    pipe_inst_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [2:0]  GAP_N   = 3'(WRITE_GAP);

    logic [1:0]    state_q, state_d;
    op_t           inst_q, inst_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [7:0]    loop_q, loop_d;
    logic [2:0]    gap_q, gap_d;
    logic          pend_q, pend_d;

    op_t  op;
    logic go, at_end, last, wr_gap;

    pipe_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (bus.prog_we),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (pc_q),
        .rdata_o (op)
    );

    assign go     = (state_q == ISSUE) && !bus.hold;
    assign at_end = {1'b0, pc_q} == (len_q - 1'b1);
    assign last   = at_end && (loop_q == 8'd1);
    assign wr_gap = is_write(op) && (GAP_N != 3'd0);

    // state and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            inst_q  <= OP_NOP;
            pc_q    <= '0;
            len_q   <= '0;
            loop_q  <= '0;
            gap_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
        end
    end

    // next-state: the drain gap is honoured before DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = ISSUE;
            end
            ISSUE: begin
                if (go) begin
                    if (wr_gap)    state_d = GAP;
                    else if (last) state_d = DONE;
                end
            end
            GAP: begin
                if (gap_q == 3'd1)
                    state_d = pend_q ? DONE : ISSUE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: issue, pc walk, loop and gap counts
    always_comb begin
        inst_d = OP_NOP;
        pc_d   = pc_q;
        len_d  = len_q;
        loop_d = loop_q;
        gap_d  = gap_q;
        pend_d = pend_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (bus.start) begin
                    len_d = ((bus.len == '0) ||
                             (bus.len > LEN_MAX))
                          ? LEN_MAX : bus.len;
                    loop_d = (bus.loops == 8'd0)
                           ? 8'd1 : bus.loops;
                    pc_d   = '0;
                    pend_d = 1'b0;
                end
            end
            (state_q == ISSUE): begin
                if (go) begin
                    inst_d = op;
                    if (at_end) begin
                        pc_d   = '0;
                        loop_d = loop_q - 8'd1;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                    if (wr_gap) begin
                        gap_d  = GAP_N;
                        pend_d = last;
                    end
                end
            end
            (state_q == GAP): begin
                gap_d = gap_q - 3'd1;
            end
            default: begin
            end
        endcase
    end

    // outputs
    always_comb begin
        bus.inst = inst_q;
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
        bus.pc   = pc_q;
    end
endmodule
